// File: rtl/spi_rocnt_readout.sv
// Serialises the frozen ring-oscillator count on MISO as {HDR, count, parity}.
// Capture starts a fixed settle interval after the ENOUT measurement window closes.
module spi_rocnt_readout #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [3:0]  HDR        = 4'b1010
) (
    input  logic             SPI_Clk,
    input  logic             SPICNT_RST,
    input  logic             ENOUT,
    input  logic [CNT_W-1:0] RO_CNT,
    output logic             MISO,
    output logic             MISO_OE,
    output logic             RD_DONE
);

    localparam int unsigned F  = CNT_W + 5;
    localparam int unsigned BW = $clog2(F + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, ARMED, SETTLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [F-1:0]    shreg;
    logic [BW-1:0]   bit_cnt;
    logic [SW-1:0]   settle_cnt;

    // MISO is the MSB of the registered shift register, so it stays a pure flop output.
    assign MISO = shreg[F-1];

    always_ff @(negedge SPI_Clk or negedge SPICNT_RST) begin
        if (!SPICNT_RST) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            MISO_OE    <= 1'b0;
            RD_DONE    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ENOUT)
                        state <= ARMED;
                end
                ARMED: begin
                    if (!ENOUT) begin
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_cnt + SW'(1) == SW'(SETTLE_CYC)) begin
                        shreg   <= {HDR, RO_CNT, ^RO_CNT};
                        MISO_OE <= 1'b1;
                        bit_cnt <= BW'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt < BW'(F)) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BW'(1);
                    end else begin
                        shreg   <= '0;
                        MISO_OE <= 1'b0;
                        RD_DONE <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rocnt_readout.sv
// Scoreboard bench: two instances (settle 2 and settle 1) share stimulus; expected
// MISO bits and RD_DONE edges are queued per instance and checked on rising edges.
module tb_spi_rocnt_readout;

    logic        SPI_Clk    = 1'b0;
    logic        SPICNT_RST = 1'b0;
    logic        ENOUT      = 1'b0;
    logic [15:0] RO_CNT     = '0;
    logic        miso_a, oe_a, done_a;
    logic        miso_b, oe_b, done_b;

    always #5 SPI_Clk = ~SPI_Clk;

    spi_rocnt_readout #(.CNT_W(16), .SETTLE_CYC(2), .HDR(4'b1010)) dut_a (
        .SPI_Clk(SPI_Clk), .SPICNT_RST(SPICNT_RST), .ENOUT(ENOUT), .RO_CNT(RO_CNT),
        .MISO(miso_a), .MISO_OE(oe_a), .RD_DONE(done_a)
    );

    spi_rocnt_readout #(.CNT_W(16), .SETTLE_CYC(1), .HDR(4'b1010)) dut_b (
        .SPI_Clk(SPI_Clk), .SPICNT_RST(SPICNT_RST), .ENOUT(ENOUT), .RO_CNT(RO_CNT),
        .MISO(miso_b), .MISO_OE(oe_b), .RD_DONE(done_b)
    );

    typedef struct {
        int   e;
        logic b;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   da[$];
    int   db[$];
    int   total  = 0;
    int   bad    = 0;
    int   edge_n = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(negedge SPI_Clk);
        #1;
        edge_n++;
    endtask

    always @(posedge SPI_Clk) begin
        exp_t x;
        if (oe_a) begin
            chk("a_oe_expected", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                x = qa.pop_front();
                chk("a_bit_edge", edge_n, x.e);
                chk("a_bit", miso_a, x.b);
            end
        end
        if (done_a && !prev_a) begin
            chk("a_done_expected", da.size() != 0, 1);
            if (da.size() != 0) chk("a_done_edge", edge_n, da.pop_front());
            chk("a_done_oe", oe_a, 0);
        end
        prev_a = done_a;
    end

    always @(posedge SPI_Clk) begin
        exp_t x;
        if (oe_b) begin
            chk("b_oe_expected", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                x = qb.pop_front();
                chk("b_bit_edge", edge_n, x.e);
                chk("b_bit", miso_b, x.b);
            end
        end
        if (done_b && !prev_b) begin
            chk("b_done_expected", db.size() != 0, 1);
            if (db.size() != 0) chk("b_done_edge", edge_n, db.pop_front());
            chk("b_done_oe", oe_b, 0);
        end
        prev_b = done_b;
    end

    task automatic do_reset();
        SPICNT_RST = 1'b0;
        ENOUT      = 1'b0;
        tick();
        chk("rst_miso_a", miso_a, 0);
        chk("rst_oe_a", oe_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_miso_b", miso_b, 0);
        chk("rst_oe_b", oe_b, 0);
        chk("rst_done_b", done_b, 0);
        qa.delete(); qb.delete(); da.delete(); db.delete();
        SPICNT_RST = 1'b1;
        edge_n     = 0;
    endtask

    // ENOUT sampled 1 on edges k1..k0-1 and 0 on edge k0; RO_CNT switches from
    // ro_init to ro just after edge k0 and to ~ro just after edge k0+2.
    task automatic run_frame(input logic [15:0] ro_init, input logic [15:0] ro,
                             input logic [20:0] frame, input int k1, input int k0,
                             input int abort);
        do_reset();
        for (int i = 0; i < 21; i++) begin
            qa.push_back('{k0 + 2 + i, frame[20-i]});
            qb.push_back('{k0 + 1 + i, frame[20-i]});
        end
        da.push_back(k0 + 23);
        db.push_back(k0 + 22);
        for (int n = 0; n < k0 + 26; n++) begin
            ENOUT  = (edge_n + 1 >= k1) && (edge_n + 1 < k0);
            RO_CNT = (edge_n + 1 <= k0) ? ro_init : (edge_n + 1 <= k0 + 2) ? ro : ~ro;
            tick();
            if (abort != 0 && edge_n == abort) begin
                chk("pre_abort_oe_a", oe_a, 1);
                chk("pre_abort_oe_b", oe_b, 1);
                SPICNT_RST = 1'b0;
                #1;
                chk("abort_oe_a", oe_a, 0);
                chk("abort_miso_a", miso_a, 0);
                chk("abort_done_a", done_a, 0);
                chk("abort_oe_b", oe_b, 0);
                chk("abort_miso_b", miso_b, 0);
                qa.delete(); qb.delete(); da.delete(); db.delete();
                return;
            end
        end
        chk("a_bits_left", qa.size(), 0);
        chk("b_bits_left", qb.size(), 0);
        chk("a_done_left", da.size(), 0);
        chk("b_done_left", db.size(), 0);
        chk("end_done_a", done_a, 1);
        chk("end_done_b", done_b, 1);
        chk("end_oe_a", oe_a, 0);
        chk("end_oe_b", oe_b, 0);
    endtask

    task automatic post_done();
        logic any;
        any = 1'b0;
        for (int n = 0; n < 40; n++) begin
            ENOUT = (n < 3);
            tick();
            any |= oe_a | oe_b;
        end
        chk("post_done_oe", any, 0);
        chk("post_done_a", done_a, 1);
        chk("post_done_b", done_b, 1);
    endtask

    task automatic run_static(input logic en);
        logic any;
        do_reset();
        ENOUT = en;
        any   = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            any |= oe_a | oe_b | done_a | done_b;
        end
        chk(en ? "stuck_high_quiet" : "no_window_quiet", any, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        run_frame(16'h1234, 16'hA5C3, 21'b1010_1010010111000011_0, 5, 21, 0);
        post_done();
        run_frame(16'hFFFF, 16'h0001, 21'b1010_0000000000000001_1, 5, 21, 0);
        run_frame(16'hFFFF, 16'h0000, 21'b1010_0000000000000000_0, 5, 6, 0);
        run_frame(16'h1234, 16'hA5C3, 21'b1010_1010010111000011_0, 5, 21, 30);
        run_frame(16'h1234, 16'hA5C3, 21'b1010_1010010111000011_0, 5, 21, 0);
        run_static(1'b0);
        run_static(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_rocnt_readout.md
# spi_rocnt_readout

Reads the captured ring-oscillator (RO) count back out of the sensor over the same SPI transaction that the SPI-clock-count window generator uses to drive the measurement. The block watches that generator's ENOUT measurement window. After the window closes and a settle interval has passed, it parallel-loads the frozen RO count and serialises it on MISO, MSB first, inside a framed word. The block sits between the RO counter outputs and the chip's SPI MISO pad. Like the window generator, it runs entirely on falling edges of SPI_Clk.

## Interface
Parameters:
- CNT_W, 16, width of the RO count.
- SETTLE_CYC, 2, falling edges between window close and count capture (≥1).
- HDR, 4'b1010, 4-bit frame header sent before the count.

Ports:
- SPI_Clk  in  1  SPI clock; all state updates on its falling edge.
- SPICNT_RST  in  1  reset, asynchronous, active-low (RSTLOW & ~SPI_CS).
- ENOUT  in  1  measurement-window enable from the SPI clock counter.
- RO_CNT  in  CNT_W  RO counter value; stable once ENOUT is low after a window.
- MISO  out  1  serial data to the SPI master.
- MISO_OE  out  1  MISO pad output enable.
- RD_DONE  out  1  frame fully sent; held until reset.

## Operation
- Frame: F = 4 + CNT_W + 1 bits = {HDR, RO_CNT, PAR}, sent MSB first.
  - PAR = ^RO_CNT, giving even parity over count+PAR.
- Shift register is F bits wide. The bit counter is wide enough to hold F.
- Reset values (SPICNT_RST low, asynchronous):
  - state IDLE; MISO 0, MISO_OE 0, RD_DONE 0.
  - shift register 0, bit counter 0, settle counter 0.
- States and transitions, evaluated at each falling edge:
  - IDLE: ENOUT sample 1 → ARMED.
  - ARMED: ENOUT sample 0 → SETTLE, settle counter cleared.
  - SETTLE: increment the settle counter. On the edge where it reaches SETTLE_CYC:
    - load the frame; drive MISO = frame MSB (HDR[3]), MISO_OE = 1;
    - set bit counter = 1 → SHIFT.
  - SHIFT, bit counter < F: shift left, MISO = next bit, increment bit counter.
  - SHIFT, bit counter == F: MISO_OE = 0, MISO = 0, RD_DONE = 1 → DONE.
  - DONE: terminal until reset. Further ENOUT pulses are ignored.
- ENOUT that never rises: stays IDLE, MISO_OE stays 0, RD_DONE stays 0.
- ENOUT that never falls: stays ARMED indefinitely.
- RO_CNT is sampled only at the load edge. Changes at any other time have no effect.
- Reset mid-frame (SPI_CS rising, or RSTLOW low): MISO_OE drops to 0 immediately with no edge needed, and all state returns to reset values. A new transaction restarts from IDLE.

## Timing
- "Sample" = the input value present just before a falling edge. Outputs change at that same edge.
- The master samples MISO on the rising edge, half a period after it is driven.
- Edge numbering: E = the edge on which SETTLE is entered.
  - Load/first bit at edge E+SETTLE_CYC.
  - Bit i (0 = frame MSB) valid from edge E+SETTLE_CYC+i.
  - Last bit at edge E+SETTLE_CYC+F−1.
  - RD_DONE=1 and MISO_OE=0 at edge E+SETTLE_CYC+F.
- Latency from the first ENOUT-low sample to the first bit on MISO: exactly SETTLE_CYC falling edges.
- A single-edge ENOUT pulse is valid: sampled 1 at edge k, 0 at edge k+1 → ARMED at k, SETTLE at k+1.
- No combinational path from inputs to MISO/MISO_OE. Both are registered; only the asynchronous reset clears them.

## Test plan
- Nominal (defaults, RO_CNT=16'hA5C3): ENOUT sampled 1 at edges 5–20, 0 at edge 21.
  - → MISO_OE rises at edge 23.
  - → MISO over edges 23–43 = 1010 1010010111000011 0.
  - → edge 44: RD_DONE=1, MISO_OE=0.
- Parity: RO_CNT=16'h0001 → PAR bit (edge 43) = 1. RO_CNT=16'h0000 → frame 1010 followed by 17 zeros.
- Settle sweep: SETTLE_CYC=1, same ENOUT pattern → first bit at edge 22, RD_DONE at edge 43. RO_CNT changing at edge 21 is captured with its new value.
- Reset mid-shift: SPICNT_RST low between edges 30 and 31 → MISO_OE=0 and MISO=0 immediately. After release, a fresh window replays the full 21-bit frame.
- No window / stuck window:
  - ENOUT held 0 for 300 edges → MISO_OE=0, RD_DONE=0 throughout.
  - ENOUT held 1 for 300 edges → no bits sent.
- Post-DONE: a second ENOUT pulse after RD_DONE → no MISO activity; RD_DONE stays 1 until reset.
